// File: rtl/gpio_collector_pkg.sv
// Shared constants for the GPIO collector: gpio_i bit map, raw input
// polarity and the control FSM state type.
package gpio_collector_pkg;

  localparam int unsigned NUM_IN  = 5;
  localparam int unsigned NUM_EVT = 5;
  localparam int unsigned GPIO_W  = 15;

  // Bits of raw_in that are active-low on the board (pwr_btn_n, chrg_stat_n, sd_cd_n)
  localparam logic [NUM_IN-1:0] RAW_POLARITY = 5'b01101;

  // gpio_i layout
  localparam int unsigned LVL_LSB = 0;
  localparam int unsigned EVT_LSB = 5;
  localparam int unsigned LP_BIT  = 10;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } ctrl_state_t;

endpackage

// File: rtl/gpio_collector_debouncer.sv
// One board input: 2-flop synchronizer, polarity normalisation, stable-count
// debounce and a combinational change strobe aligned with the level update.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  input  logic run,
  output logic level,
  output logic change
);

  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          norm;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  assign norm   = sync_q[1] ^ INVERT;
  assign change = run && (norm != level_q) && (cnt_q == TERM);
  assign level  = level_q;

  // Two-stage synchronizer for the asynchronous board pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  // Stable level: direct load at end of INIT, otherwise debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= '0;
      level_q <= norm;
    end else if (run) begin
      if (norm != level_q) begin
        if (cnt_q == TERM) begin
          cnt_q   <= '0;
          level_q <= ~level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_collector.sv
// GPIO collector: debounces five board inputs, latches sticky change and
// long-press events for an AXI GPIO input channel and raises a level irq.
module gpio_collector
  import gpio_collector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 300000000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NUM_IN-1:0] raw_in,
  input  logic [NUM_EVT:0]  evt_clr,
  output logic [GPIO_W-1:0] gpio_i,
  output logic              irq
);

  localparam int unsigned   DW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DTERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned   LW    = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LTERM = LW'(LONG_PRESS_CYCLES - 1);

  ctrl_state_t       state_q;
  logic [DW-1:0]     init_cnt_q;
  logic              load;
  logic              run;
  logic [NUM_IN-1:0] level;
  logic [NUM_IN-1:0] change;
  logic [NUM_EVT:0]  clr_q;
  logic [NUM_EVT:0]  clr_rise;
  logic [NUM_EVT:0]  evt_set;
  logic [NUM_EVT:0]  evt_q;
  logic [LW-1:0]     lp_cnt_q;
  logic              lp_done_q;
  logic              lp_set;

  assign load = (state_q == ST_INIT) && (init_cnt_q == DTERM);
  assign run  = (state_q == ST_RUN);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (RAW_POLARITY[i])
    ) u_deb (
      .clk   (aclk),
      .rst_n (aresetn),
      .raw   (raw_in[i]),
      .load  (load),
      .run   (run),
      .level (level[i]),
      .change(change[i])
    );
  end

  // Control FSM: settle for one debounce period, then run
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == DTERM) begin
            state_q    <= ST_RUN;
            init_cnt_q <= '0;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Long press: count while pressed, saturate, fire once per press
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lp_cnt_q  <= '0;
      lp_done_q <= 1'b0;
    end else if (!level[0]) begin
      lp_cnt_q  <= '0;
      lp_done_q <= 1'b0;
    end else if (lp_cnt_q != LTERM) begin
      lp_cnt_q <= lp_cnt_q + 1'b1;
    end else begin
      lp_done_q <= 1'b1;
    end
  end

  assign lp_set   = level[0] && (lp_cnt_q == LTERM) && !lp_done_q;
  assign evt_set  = {lp_set, change};
  assign clr_rise = evt_clr & ~clr_q;

  // Sticky events with registered clear edge detect; set beats clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      clr_q <= '0;
      evt_q <= '0;
      irq   <= 1'b0;
    end else begin
      clr_q <= evt_clr;
      evt_q <= evt_set | (evt_q & ~clr_rise);
      irq   <= |evt_q;
    end
  end

  // Output map onto the AXI GPIO input channel
  always_comb begin
    gpio_i                          = '0;
    gpio_i[LVL_LSB +: NUM_IN]       = level;
    gpio_i[EVT_LSB +: NUM_EVT]      = evt_q[NUM_EVT-1:0];
    gpio_i[LP_BIT]                  = evt_q[NUM_EVT];
  end

endmodule

// File: tb/tb_gpio_collector.sv
// Directed bench for gpio_collector with small debounce/long-press periods.
// Expected {irq, gpio_i} words are queued as stimulus is applied and popped
// when the output is sampled on the falling clock edge.
module tb_gpio_collector;

  logic        aclk;
  logic        aresetn;
  logic [4:0]  raw_in;
  logic [5:0]  evt_clr;
  logic [14:0] gpio_i;
  logic        irq;

  int unsigned total;
  int unsigned bad;
  logic [15:0] exp_q[$];

  gpio_collector #(
    .DEBOUNCE_CYCLES  (8),
    .LONG_PRESS_CYCLES(32)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .raw_in (raw_in),
    .evt_clr(evt_clr),
    .gpio_i (gpio_i),
    .irq    (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // drive normalized (active-high) levels; board pins 0,2,3 are active-low
  task automatic set_norm(input logic [4:0] n);
    raw_in = n ^ 5'b01101;
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w);
  endtask

  task automatic check(input string tag);
    logic [15:0] exp_w;
    logic [15:0] obs_w;
    exp_w = exp_q.pop_front();
    obs_w = {irq, gpio_i};
    total++;
    assert (obs_w === exp_w)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_w, exp_w);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    aresetn = 1'b0;
    raw_in  = 5'b11111;
    evt_clr = '0;

    // reset state
    step(); step();
    expect_word(16'h0000); check("reset");

    // INIT with raw 11111 -> normalized 10010
    aresetn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      expect_word(e < 8 ? 16'h0000 : 16'h0012);
      step(); check("init");
    end

    // go to all-normalized-zero: usb_vbus and sensor_rdy fall
    set_norm(5'b00000);
    for (int e = 1; e <= 11; e++) begin
      if (e < 10)       expect_word(16'h0012);
      else if (e == 10) expect_word(16'h0240);
      else              expect_word(16'h8240);
      step(); check("fall_to_zero");
    end
    evt_clr = 6'b010010;
    expect_word(16'h8000); step(); check("clr14_a");
    expect_word(16'h0000); step(); check("clr14_b");
    evt_clr = '0;

    // raise usb_vbus: level+event at 10, irq at 11
    set_norm(5'b00010);
    for (int e = 1; e <= 11; e++) begin
      if (e < 10)       expect_word(16'h0000);
      else if (e == 10) expect_word(16'h0042);
      else              expect_word(16'h8042);
      step(); check("usb_rise");
    end
    evt_clr = 6'b000010;
    expect_word(16'h8002); step(); check("clr1_a");
    expect_word(16'h0002); step(); check("clr1_b");
    evt_clr = '0;

    // 7-cycle sd_cd glitch: no change
    set_norm(5'b01010);
    for (int e = 1; e <= 20; e++) begin
      expect_word(16'h0002);
      step(); check("glitch7");
      if (e == 7) set_norm(5'b00010);
    end

    // 9-cycle sd_cd pulse: rises at 10, falls at 19, event stays
    set_norm(5'b01010);
    for (int e = 1; e <= 22; e++) begin
      if (e < 10)       expect_word(16'h0002);
      else if (e == 10) expect_word(16'h010A);
      else if (e < 19)  expect_word(16'h810A);
      else              expect_word(16'h8102);
      step(); check("pulse9");
      if (e == 9) set_norm(5'b00010);
    end
    evt_clr = 6'b001000;
    expect_word(16'h8002); step(); check("clr3_a");
    expect_word(16'h0002); step(); check("clr3_b");
    evt_clr = '0;

    // power button held 50 cycles: level at 10, long press at 42,
    // long press cleared at 46 while still held and must not re-fire
    set_norm(5'b00011);
    for (int e = 1; e <= 62; e++) begin
      if (e < 10)       expect_word(16'h0002);
      else if (e == 10) expect_word(16'h0023);
      else if (e < 42)  expect_word(16'h8023);
      else if (e < 46)  expect_word(16'h8423);
      else if (e < 60)  expect_word(16'h8023);
      else              expect_word(16'h8022);
      step(); check("long_press");
      if (e == 45) evt_clr = 6'b100000;
      if (e == 47) evt_clr = '0;
      if (e == 50) set_norm(5'b00010);
    end
    evt_clr = 6'b000001;
    expect_word(16'h8002); step(); check("clr0_a");
    expect_word(16'h0002); step(); check("clr0_b");
    evt_clr = '0;

    // clear rising on the same cycle as a new usb_vbus event: set wins
    set_norm(5'b00000);
    for (int e = 1; e <= 12; e++) begin
      if (e < 10)       expect_word(16'h0002);
      else if (e == 10) expect_word(16'h0040);
      else              expect_word(16'h8040);
      step(); check("set_wins");
      if (e == 9) evt_clr = 6'b000010;
    end
    evt_clr = '0;
    expect_word(16'h8040); step(); check("clr_low");
    evt_clr = 6'b000010;
    expect_word(16'h8000); step(); check("clr_again_a");
    expect_word(16'h0000); step(); check("clr_again_b");
    evt_clr = '0;

    // reset mid-debounce
    set_norm(5'b00010);
    for (int e = 1; e <= 5; e++) begin
      expect_word(16'h0000);
      step(); check("pre_reset");
    end
    aresetn = 1'b0;
    #1;
    expect_word(16'h0000); check("async_reset");
    step(); step();
    expect_word(16'h0000); check("held_reset");
    aresetn = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      expect_word(e < 8 ? 16'h0000 : 16'h0002);
      step(); check("reinit");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
